// File: rtl/wb_stage_if.sv
// Writeback stage bus: execute handshake, memory read response and register-file write port.
// Forwarding signals exist only when WB_FWD_EN is defined.
interface wb_stage_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned RA_W = 5
);
  logic            ex_valid;
  logic            ex_ready;
  logic [RA_W-1:0] ex_rd;
  logic [XLEN-1:0] ex_result;
  logic            ex_is_load;
  logic [2:0]      ex_funct3;
  logic            mem_rvalid;
  logic [XLEN-1:0] mem_rdata;
  logic            mem_rerr;
  logic            rf_wen;
  logic [RA_W-1:0] rf_rd;
  logic [XLEN-1:0] rf_wdata;
  logic            pend_valid;
  logic [RA_W-1:0] pend_rd;
  logic            err;
`ifdef WB_FWD_EN
  logic            fwd_valid;
  logic [RA_W-1:0] fwd_rd;
  logic [XLEN-1:0] fwd_wdata;
`endif

  // Master is the execute/memory side; slave is the writeback stage.
  modport master (
    output ex_valid, ex_rd, ex_result, ex_is_load, ex_funct3,
    output mem_rvalid, mem_rdata, mem_rerr,
    input  ex_ready, rf_wen, rf_rd, rf_wdata, pend_valid, pend_rd, err
`ifdef WB_FWD_EN
    , input fwd_valid, fwd_rd, fwd_wdata
`endif
  );

  modport slave (
    input  ex_valid, ex_rd, ex_result, ex_is_load, ex_funct3,
    input  mem_rvalid, mem_rdata, mem_rerr,
    output ex_ready, rf_wen, rf_rd, rf_wdata, pend_valid, pend_rd, err
`ifdef WB_FWD_EN
    , output fwd_valid, fwd_rd, fwd_wdata
`endif
  );
endinterface

// File: rtl/wb_stage.sv
// Writeback stage: ALU results pass through, loads wait for the memory response and are extracted.
// Optional macro WB_FWD_EN adds combinational forwarding of next cycle's register-file write.
module wb_stage #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned RA_W        = 5,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input logic     clock,
  input logic     reset,
  wb_stage_if.slave bus
);

  typedef enum logic [0:0] {StIdle, StWaitMem} state_e;

  state_e          state_q;
  logic [15:0]     cnt_q;
  logic [2:0]      f3_q;
  logic [1:0]      addr_q;
  logic            rf_wen_q;
  logic [RA_W-1:0] rf_rd_q;
  logic [XLEN-1:0] rf_wdata_q;
  logic            pend_valid_q;
  logic [RA_W-1:0] pend_rd_q;
  logic            err_q;

  logic            xfer;
  logic            wr_ok_ex;
  logic            wr_ok_pend;
  logic            timeout;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [XLEN-1:0] ld_data;

  assign bus.ex_ready   = (state_q == StIdle);
  assign bus.rf_wen     = rf_wen_q;
  assign bus.rf_rd      = rf_rd_q;
  assign bus.rf_wdata   = rf_wdata_q;
  assign bus.pend_valid = pend_valid_q;
  assign bus.pend_rd    = pend_rd_q;
  assign bus.err        = err_q;

  // x0 is hardwired and only 16 registers exist, so those indices are never written.
  always_comb begin
    xfer       = bus.ex_valid && (state_q == StIdle);
    wr_ok_ex   = (bus.ex_rd != '0) && (bus.ex_rd < RA_W'(16));
    wr_ok_pend = (pend_rd_q != '0) && (pend_rd_q < RA_W'(16));
    timeout    = (cnt_q == 16'(TIMEOUT_CYC - 1));
  end

  // Little-endian lane extraction; undefined funct3 encodings fall back to LW.
  always_comb begin
    ld_byte = 8'h00;
    unique case (addr_q)
      2'd0: ld_byte = bus.mem_rdata[7:0];
      2'd1: ld_byte = bus.mem_rdata[15:8];
      2'd2: ld_byte = bus.mem_rdata[23:16];
      2'd3: ld_byte = bus.mem_rdata[31:24];
      default: ld_byte = 8'h00;
    endcase
    ld_half = addr_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    ld_data = bus.mem_rdata;
    case (f3_q)
      3'b000:  ld_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{(XLEN-16){ld_half[15]}}, ld_half};
      3'b100:  ld_data = {{(XLEN-8){1'b0}}, ld_byte};
      3'b101:  ld_data = {{(XLEN-16){1'b0}}, ld_half};
      default: ld_data = bus.mem_rdata;
    endcase
  end

`ifdef WB_FWD_EN
  assign bus.fwd_valid = (xfer && !bus.ex_is_load && wr_ok_ex) ||
                         ((state_q == StWaitMem) && bus.mem_rvalid && !bus.mem_rerr && wr_ok_pend);
  assign bus.fwd_rd    = (state_q == StIdle) ? bus.ex_rd : pend_rd_q;
  assign bus.fwd_wdata = (state_q == StIdle) ? bus.ex_result : ld_data;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      f3_q         <= '0;
      addr_q       <= '0;
      rf_wen_q     <= 1'b0;
      rf_rd_q      <= '0;
      rf_wdata_q   <= '0;
      pend_valid_q <= 1'b0;
      pend_rd_q    <= '0;
      err_q        <= 1'b0;
    end else begin
      rf_wen_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // A response with nothing outstanding is a protocol error, even alongside a transfer.
          if (bus.mem_rvalid) err_q <= 1'b1;
          if (xfer) begin
            if (bus.ex_is_load) begin
              state_q      <= StWaitMem;
              cnt_q        <= '0;
              f3_q         <= bus.ex_funct3;
              addr_q       <= bus.ex_result[1:0];
              pend_valid_q <= 1'b1;
              pend_rd_q    <= bus.ex_rd;
            end else if (wr_ok_ex) begin
              rf_wen_q   <= 1'b1;
              rf_rd_q    <= bus.ex_rd;
              rf_wdata_q <= bus.ex_result;
            end
          end
        end
        StWaitMem: begin
          if (bus.mem_rvalid) begin
            state_q      <= StIdle;
            pend_valid_q <= 1'b0;
            if (bus.mem_rerr) begin
              err_q <= 1'b1;
            end else if (wr_ok_pend) begin
              rf_wen_q   <= 1'b1;
              rf_rd_q    <= pend_rd_q;
              rf_wdata_q <= ld_data;
            end
          end else if (timeout) begin
            state_q      <= StIdle;
            pend_valid_q <= 1'b0;
            err_q        <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios plus randomized traffic against a
// transaction-level reference model.
module tb_wb_stage;
  localparam int unsigned Xlen    = 32;
  localparam int unsigned RaW     = 5;
  localparam int unsigned Timeout = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  wb_stage_if #(.XLEN(Xlen), .RA_W(RaW)) bus ();

  wb_stage #(.XLEN(Xlen), .RA_W(RaW), .TIMEOUT_CYC(Timeout)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: one outstanding load at most, described by what it is waiting for.
  bit          m_busy;
  logic [4:0]  m_rd;
  logic [2:0]  m_f3;
  logic [1:0]  m_addr;
  int          m_waited;
  logic        e_wen;
  logic [4:0]  e_rd;
  logic [31:0] e_wdata;
  logic [4:0]  e_pend_rd;
  logic        e_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] a,
                                           input logic [31:0] w);
    int unsigned b, h;
    b = (w >> (8 * a)) & 32'hFF;
    h = (w >> (16 * a[1])) & 32'hFFFF;
    case (f3)
      3'b000:  return (b >= 128) ? b - 256 : b;
      3'b001:  return (h >= 32768) ? h - 65536 : h;
      3'b100:  return b;
      3'b101:  return h;
      default: return w;
    endcase
  endfunction

  function automatic bit writable(input logic [4:0] rd);
    return (rd != 0) && (rd < 16);
  endfunction

  task automatic model_reset();
    m_busy = 0; m_rd = 0; m_f3 = 0; m_addr = 0; m_waited = 0;
    e_wen = 0; e_rd = 0; e_wdata = 0; e_pend_rd = 0; e_err = 0;
  endtask

  task automatic model_edge();
    e_wen = 0;
    if (!m_busy) begin
      if (bus.mem_rvalid) e_err = 1;
      if (bus.ex_valid) begin
        if (bus.ex_is_load) begin
          m_busy = 1; m_rd = bus.ex_rd; m_f3 = bus.ex_funct3;
          m_addr = bus.ex_result[1:0]; m_waited = 0; e_pend_rd = bus.ex_rd;
        end else if (writable(bus.ex_rd)) begin
          e_wen = 1; e_rd = bus.ex_rd; e_wdata = bus.ex_result;
        end
      end
    end else if (bus.mem_rvalid) begin
      m_busy = 0;
      if (bus.mem_rerr) e_err = 1;
      else if (writable(m_rd)) begin
        e_wen = 1; e_rd = m_rd; e_wdata = ref_load(m_f3, m_addr, bus.mem_rdata);
      end
    end else begin
      m_waited++;
      if (m_waited == Timeout) begin
        m_busy = 0; e_err = 1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".rf_wen"},     32'(bus.rf_wen),     32'(e_wen));
    check({tag, ".rf_rd"},      32'(bus.rf_rd),      32'(e_rd));
    check({tag, ".rf_wdata"},   bus.rf_wdata,        e_wdata);
    check({tag, ".pend_valid"}, 32'(bus.pend_valid), 32'(m_busy));
    check({tag, ".pend_rd"},    32'(bus.pend_rd),    32'(e_pend_rd));
    check({tag, ".err"},        32'(bus.err),        32'(e_err));
    check({tag, ".ex_ready"},   32'(bus.ex_ready),   32'(!m_busy));
  endtask

  task automatic step(input string tag, input logic ev, input logic [4:0] rd,
                      input logic [31:0] res, input logic ld, input logic [2:0] f3,
                      input logic rv, input logic [31:0] rdata, input logic rerr);
    bus.ex_valid = ev; bus.ex_rd = rd; bus.ex_result = res; bus.ex_is_load = ld;
    bus.ex_funct3 = f3; bus.mem_rvalid = rv; bus.mem_rdata = rdata; bus.mem_rerr = rerr;
    @(posedge clock);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step("idle", 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    check_all("reset");
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    bus.ex_valid = 0; bus.ex_rd = 0; bus.ex_result = 0; bus.ex_is_load = 0;
    bus.ex_funct3 = 0; bus.mem_rvalid = 0; bus.mem_rdata = 0; bus.mem_rerr = 0;
    model_reset();
    do_reset();

    // ALU pass-through, then x0 and out-of-range destinations.
    step("alu5", 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    check("alu5.wdata", bus.rf_wdata, 32'hDEADBEEF);
    idle(1);
    step("alu0", 1, 0, 32'h11111111, 0, 0, 0, 0, 0);
    step("alu17", 1, 17, 32'h22222222, 0, 0, 0, 0, 0);
    step("b2b_a", 1, 1, 32'hA, 0, 0, 0, 0, 0);
    step("b2b_b", 1, 2, 32'hB, 0, 0, 0, 0, 0);

    // LB from byte 3, response after 4 wait cycles.
    step("lb", 1, 7, 32'h0000_1003, 1, 3'b000, 0, 0, 0);
    idle(4);
    step("lb_rsp", 0, 0, 0, 0, 0, 1, 32'h80FF1234, 0);
    check("lb.value", bus.rf_wdata, 32'hFFFFFF80);
    step("lhu", 1, 9, 32'h0000_2002, 1, 3'b101, 0, 0, 0);
    idle(2);
    step("lhu_rsp", 0, 0, 0, 0, 0, 1, 32'h80FF1234, 0);
    check("lhu.value", bus.rf_wdata, 32'h000080FF);

    // Timeout after exactly Timeout wait cycles.
    step("to_ld", 1, 3, 32'h0, 1, 3'b010, 0, 0, 0);
    idle(Timeout);
    check("to.err", 32'(bus.err), 32'd1);
    check("to.ready", 32'(bus.ex_ready), 32'd1);
    do_reset();
    check("to.err_cleared", 32'(bus.err), 32'd0);

    // Unexpected response in IDLE; then an erroring response.
    step("idle_rv", 0, 0, 0, 0, 0, 1, 32'h12345678, 0);
    check("idle_rv.err", 32'(bus.err), 32'd1);
    do_reset();
    step("rerr_ld", 1, 6, 32'h4, 1, 3'b010, 0, 0, 0);
    step("rerr_rsp", 0, 0, 0, 0, 0, 1, 32'hCAFEF00D, 1);
    check("rerr.err", 32'(bus.err), 32'd1);
    do_reset();

    // Reset in the middle of a wait; the late response is unexpected.
    step("mid_ld", 1, 4, 32'h8, 1, 3'b010, 0, 0, 0);
    idle(2);
    do_reset();
    step("late_rsp", 0, 0, 0, 0, 0, 1, 32'h55AA55AA, 0);
    check("late.err", 32'(bus.err), 32'd1);

    // Randomized traffic in independent blocks.
    for (int blk = 0; blk < 20; blk++) begin
      do_reset();
      for (int c = 0; c < 100; c++) begin
        logic rv;
        rv = m_busy ? ($urandom_range(0, 99) < 30) : ($urandom_range(0, 99) < 2);
        step("rand", 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
             1'($urandom_range(0, 99) < 40), 3'($urandom_range(0, 7)), rv, $urandom,
             1'($urandom_range(0, 9) == 0));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
